// File: rtl/pong_match_ctrl_if.sv
// Bundle of the signals that connect the match controller to the video timing,
// the player inputs and the paddle/ball blocks.
interface pong_match_ctrl_if #(
    parameter int SCORE_WIDTH = 4
);
    // Inputs to the controller
    logic                   vertical_sync;
    logic                   start_button;
    logic                   ball_out_left;
    logic                   ball_out_right;

    // Outputs from the controller
    logic                   frame_tick;
    logic                   paddle_enable;
    logic                   ball_hold;
    logic                   ball_serve;
    logic                   serve_dir;
    logic [SCORE_WIDTH-1:0] score_left;
    logic [SCORE_WIDTH-1:0] score_right;
    logic                   winner;
    logic [2:0]             state;

    // Environment side: drives vsync, buttons and goal detection
    modport master (
        output vertical_sync, start_button, ball_out_left, ball_out_right,
        input  frame_tick, paddle_enable, ball_hold, ball_serve, serve_dir,
               score_left, score_right, winner, state
    );

    // Controller side
    modport slave (
        input  vertical_sync, start_button, ball_out_left, ball_out_right,
        output frame_tick, paddle_enable, ball_hold, ball_serve, serve_dir,
               score_left, score_right, winner, state
    );
endinterface

// File: rtl/pong_match_ctrl.sv
// Match-level sequencer for the two-paddle game: derives the frame tick from
// vsync, runs idle/serve/play/point/game-over, keeps the scores and decides
// when paddles and ball may move.
module pong_match_ctrl #(
    parameter int                     SCORE_WIDTH  = 4,
    parameter logic [SCORE_WIDTH-1:0] WIN_SCORE    = 4'd7,
    parameter int                     COUNT_WIDTH  = 8,
    parameter logic [COUNT_WIDTH-1:0] SERVE_FRAMES = 8'd60,
    parameter logic [COUNT_WIDTH-1:0] POINT_FRAMES = 8'd30
) (
    input  logic              pixel_clock,
    input  logic              reset,
    pong_match_ctrl_if.slave  bus
);

    // State encoding
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SERVE     = 3'd1;
    localparam logic [2:0] ST_PLAY      = 3'd2;
    localparam logic [2:0] ST_POINT     = 3'd3;
    localparam logic [2:0] ST_GAME_OVER = 3'd4;

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SCORE_WIDTH-1:0] SCORE_ONE = {{(SCORE_WIDTH-1){1'b0}}, 1'b1};

    // A zero delay would never expire, so it is stretched to one frame
    localparam logic [COUNT_WIDTH-1:0] SERVE_LOAD = (SERVE_FRAMES == '0) ? CNT_ONE : SERVE_FRAMES;
    localparam logic [COUNT_WIDTH-1:0] POINT_LOAD = (POINT_FRAMES == '0) ? CNT_ONE : POINT_FRAMES;

    // Edge detection on vsync (bit 0) and start button (bit 1)
    logic [1:0] raw_w;
    logic [1:0] rise_w;
    logic       tick_w;
    logic       start_edge_w;

    assign raw_w        = {bus.start_button, bus.vertical_sync};
    assign tick_w       = rise_w[0];
    assign start_edge_w = rise_w[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_edge
            logic last_q;

            // Previous level; preset high so a level already up at reset release is not an edge
            always_ff @(posedge pixel_clock) begin
                if (reset) begin
                    last_q <= 1'b1;
                end else begin
                    last_q <= raw_w[gi];
                end
            end

            assign rise_w[gi] = raw_w[gi] & ~last_q;
        end
    endgenerate

    // Registered match state
    logic [2:0]             state_q,       state_d;
    logic [COUNT_WIDTH-1:0] countdown_q,   countdown_d;
    logic [SCORE_WIDTH-1:0] score_left_q,  score_left_d;
    logic [SCORE_WIDTH-1:0] score_right_q, score_right_d;
    logic                   serve_dir_q,   serve_dir_d;
    logic                   winner_q,      winner_d;
    logic                   ball_serve_q,  ball_serve_d;
    logic                   frame_tick_q;

    // Scores stop at the winning value and never wrap
    function automatic logic [SCORE_WIDTH-1:0] sat_inc(input logic [SCORE_WIDTH-1:0] s);
        sat_inc = (s >= WIN_SCORE) ? s : s + SCORE_ONE;
    endfunction

    logic expired_w;
    assign expired_w = tick_w && (countdown_q <= CNT_ONE);

    // Next-state and datapath decisions for the match FSM
    always_comb begin
        state_d       = state_q;
        countdown_d   = countdown_q;
        score_left_d  = score_left_q;
        score_right_d = score_right_q;
        serve_dir_d   = serve_dir_q;
        winner_d      = winner_q;
        ball_serve_d  = 1'b0;

        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                // A new match starts straight into the serve countdown
                if (start_edge_w) begin
                    score_left_d  = '0;
                    score_right_d = '0;
                    serve_dir_d   = 1'b0;
                    countdown_d   = SERVE_LOAD;
                    state_d       = ST_SERVE;
                end
            end

            ST_SERVE: begin
                if (expired_w) begin
                    ball_serve_d = 1'b1;
                    state_d      = ST_PLAY;
                end else if (tick_w) begin
                    countdown_d = countdown_q - CNT_ONE;
                end
            end

            ST_PLAY: begin
                // Goal lines are watched every clock, not only on frame ticks
                if (bus.ball_out_left && bus.ball_out_right) begin
                    countdown_d = POINT_LOAD;
                    state_d     = ST_POINT;
                end else if (bus.ball_out_left) begin
                    score_right_d = sat_inc(score_right_q);
                    serve_dir_d   = 1'b0;
                    countdown_d   = POINT_LOAD;
                    state_d       = ST_POINT;
                end else if (bus.ball_out_right) begin
                    score_left_d = sat_inc(score_left_q);
                    serve_dir_d  = 1'b1;
                    countdown_d  = POINT_LOAD;
                    state_d      = ST_POINT;
                end
            end

            ST_POINT: begin
                // Goal inputs ignored here so a held level cannot score twice
                if (expired_w) begin
                    if ((score_left_q == WIN_SCORE) || (score_right_q == WIN_SCORE)) begin
                        winner_d = (score_right_q == WIN_SCORE);
                        state_d  = ST_GAME_OVER;
                    end else begin
                        countdown_d = SERVE_LOAD;
                        state_d     = ST_SERVE;
                    end
                end else if (tick_w) begin
                    countdown_d = countdown_q - CNT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, scores and pulse registers; reset abandons any match in progress
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            countdown_q   <= '0;
            score_left_q  <= '0;
            score_right_q <= '0;
            serve_dir_q   <= 1'b0;
            winner_q      <= 1'b0;
            ball_serve_q  <= 1'b0;
            frame_tick_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            countdown_q   <= countdown_d;
            score_left_q  <= score_left_d;
            score_right_q <= score_right_d;
            serve_dir_q   <= serve_dir_d;
            winner_q      <= winner_d;
            ball_serve_q  <= ball_serve_d;
            frame_tick_q  <= tick_w;
        end
    end

    // Output decode from registered state
    assign bus.frame_tick    = frame_tick_q;
    assign bus.paddle_enable = (state_q == ST_SERVE) || (state_q == ST_PLAY);
    assign bus.ball_hold     = (state_q != ST_PLAY);
    assign bus.ball_serve    = ball_serve_q;
    assign bus.serve_dir     = serve_dir_q;
    assign bus.score_left    = score_left_q;
    assign bus.score_right   = score_right_q;
    assign bus.winner        = winner_q;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed table-driven bench for pong_match_ctrl with short delays
// (serve 3 frames, point 2 frames, match to 2) and vsync rising every 10 cycles.
module tb_pong_match_ctrl;

    logic clk;
    logic rst;

    pong_match_ctrl_if #(.SCORE_WIDTH(4)) bus ();

    pong_match_ctrl #(
        .SCORE_WIDTH (4),
        .WIN_SCORE   (4'd2),
        .COUNT_WIDTH (8),
        .SERVE_FRAMES(8'd3),
        .POINT_FRAMES(8'd2)
    ) dut (
        .pixel_clock(clk),
        .reset      (rst),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Pulse counters sampled mid-cycle
    int ft_cnt    = 0;
    int serve_cnt = 0;
    int serve_bad = 0;

    always @(negedge clk) begin
        if (bus.frame_tick === 1'b1) ft_cnt <= ft_cnt + 1;
        if (bus.ball_serve === 1'b1) begin
            serve_cnt <= serve_cnt + 1;
            if (bus.state !== 3'd2) serve_bad <= serve_bad + 1;
        end
    end

    typedef struct {
        int   ncyc;   // cycles in this step
        int   hold;   // cycle index at which inputs are released
        bit   vs;     // vsync toggling (rise at cycle 0, 10, ...)
        bit   st;
        bit   bl;
        bit   br;
        int   est;
        int   esl;
        int   esr;
        bit   edir;
        bit   ewin;
        int   eser;   // ball_serve pulses expected during step
    } vec_t;

    localparam int NV = 29;
    vec_t tbl [NV];

    function automatic vec_t mk(int ncyc, int hold, bit vs, bit st, bit bl, bit br,
                                int est, int esl, int esr, bit edir, bit ewin, int eser);
        vec_t v;
        v.ncyc = ncyc; v.hold = hold; v.vs = vs; v.st = st; v.bl = bl; v.br = br;
        v.est = est; v.esl = esl; v.esr = esr; v.edir = edir; v.ewin = ewin; v.eser = eser;
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        vec_t v;
        int   ft0;
        int   sv0;

        //            ncyc hold vs st bl br  st  sl sr dir win ser
        tbl[0]  = mk(  2,   1,  0, 1, 0, 0,  1,  0, 0, 0,  0,  0);  // start -> SERVE
        tbl[1]  = mk( 20,   0,  1, 0, 0, 0,  1,  0, 0, 0,  0,  0);  // 2 ticks, still SERVE
        tbl[2]  = mk( 10,   0,  1, 0, 0, 0,  2,  0, 0, 0,  0,  1);  // 3rd tick -> PLAY
        tbl[3]  = mk( 10,  99,  1, 0, 0, 1,  3,  1, 0, 1,  0,  0);  // right out held
        tbl[4]  = mk( 20,  99,  1, 0, 0, 1,  1,  1, 0, 1,  0,  0);  // still held, POINT->SERVE
        tbl[5]  = mk( 20,  99,  1, 0, 0, 1,  1,  1, 0, 1,  0,  0);  // 50 cycles total held
        tbl[6]  = mk( 10,   0,  1, 0, 0, 0,  2,  1, 0, 1,  0,  1);  // released -> PLAY
        tbl[7]  = mk( 10,   1,  1, 0, 1, 1,  3,  1, 0, 1,  0,  0);  // both out: replay
        tbl[8]  = mk( 20,   0,  1, 0, 0, 0,  1,  1, 0, 1,  0,  0);
        tbl[9]  = mk( 30,   0,  1, 0, 0, 0,  2,  1, 0, 1,  0,  1);
        tbl[10] = mk( 10,   1,  1, 0, 0, 1,  3,  2, 0, 1,  0,  0);  // left reaches 2
        tbl[11] = mk( 10,   0,  1, 0, 0, 0,  3,  2, 0, 1,  0,  0);  // one tick: still POINT
        tbl[12] = mk( 10,   0,  1, 0, 0, 0,  4,  2, 0, 1,  0,  0);  // GAME_OVER, left wins
        tbl[13] = mk( 10,   1,  1, 0, 1, 1,  4,  2, 0, 1,  0,  0);  // goals ignored
        tbl[14] = mk(  2,   1,  0, 1, 0, 0,  1,  0, 0, 0,  0,  0);  // restart
        tbl[15] = mk( 30,   0,  1, 0, 0, 0,  2,  0, 0, 0,  0,  1);
        tbl[16] = mk( 10,   1,  1, 0, 1, 0,  3,  0, 1, 0,  0,  0);
        tbl[17] = mk( 20,   0,  1, 0, 0, 0,  1,  0, 1, 0,  0,  0);
        tbl[18] = mk( 30,   0,  1, 0, 0, 0,  2,  0, 1, 0,  0,  1);
        tbl[19] = mk( 10,   1,  1, 0, 1, 0,  3,  0, 2, 0,  0,  0);
        tbl[20] = mk( 20,   0,  1, 0, 0, 0,  4,  0, 2, 0,  1,  0);  // right wins
        tbl[21] = mk(  2,   1,  0, 1, 0, 0,  1,  0, 0, 0,  0,  0);
        tbl[22] = mk( 30,   0,  1, 0, 0, 0,  2,  0, 0, 0,  0,  1);
        tbl[23] = mk( 10,   1,  1, 0, 1, 0,  3,  0, 1, 0,  0,  0);
        tbl[24] = mk( 20,   0,  1, 0, 0, 0,  1,  0, 1, 0,  0,  0);
        tbl[25] = mk( 30,   0,  1, 0, 0, 0,  2,  0, 1, 0,  0,  1);
        tbl[26] = mk( 10,   1,  1, 0, 0, 1,  3,  1, 1, 1,  0,  0);
        tbl[27] = mk( 20,   0,  1, 0, 0, 0,  1,  1, 1, 1,  0,  0);
        tbl[28] = mk( 30,   0,  1, 0, 0, 0,  2,  1, 1, 1,  0,  1);  // PLAY at 1/1

        // Reset with vsync held high
        rst = 1'b1;
        bus.vertical_sync  = 1'b1;
        bus.start_button   = 1'b0;
        bus.ball_out_left  = 1'b0;
        bus.ball_out_right = 1'b0;
        repeat (3) cyc();
        chk("rst_state",   int'(bus.state), 0);
        chk("rst_sl",      int'(bus.score_left), 0);
        chk("rst_sr",      int'(bus.score_right), 0);
        chk("rst_hold",    int'(bus.ball_hold), 1);
        chk("rst_pe",      int'(bus.paddle_enable), 0);
        chk("rst_serve",   int'(bus.ball_serve), 0);
        chk("rst_ft",      int'(bus.frame_tick), 0);
        chk("rst_dir",     int'(bus.serve_dir), 0);
        chk("rst_winner",  int'(bus.winner), 0);
        $display("reset: state=%0d score=%0d/%0d", bus.state, bus.score_left, bus.score_right);

        rst = 1'b0;
        ft0 = ft_cnt;
        repeat (10) cyc();
        chk("vsync_high_at_release_ticks", ft_cnt - ft0, 0);
        bus.vertical_sync = 1'b0;
        repeat (5) cyc();
        bus.vertical_sync = 1'b1;
        repeat (5) cyc();
        bus.vertical_sync = 1'b0;
        repeat (5) cyc();
        chk("first_real_vsync_ticks", ft_cnt - ft0, 1);
        chk("idle_after_ticks", int'(bus.state), 0);

        // Table-driven match sequence
        for (int s = 0; s < NV; s++) begin
            v   = tbl[s];
            ft0 = ft_cnt;
            sv0 = serve_cnt;
            bus.start_button   = v.st;
            bus.ball_out_left  = v.bl;
            bus.ball_out_right = v.br;
            for (int i = 0; i < v.ncyc; i++) begin
                if (i == v.hold) begin
                    bus.start_button   = 1'b0;
                    bus.ball_out_left  = 1'b0;
                    bus.ball_out_right = 1'b0;
                end
                bus.vertical_sync = v.vs && ((i % 10) < 5);
                cyc();
            end
            bus.vertical_sync = 1'b0;

            chk($sformatf("step%0d_state", s), int'(bus.state), v.est);
            chk($sformatf("step%0d_score_left", s), int'(bus.score_left), v.esl);
            chk($sformatf("step%0d_score_right", s), int'(bus.score_right), v.esr);
            chk($sformatf("step%0d_serve_dir", s), int'(bus.serve_dir), int'(v.edir));
            chk($sformatf("step%0d_paddle_enable", s), int'(bus.paddle_enable),
                (v.est == 1 || v.est == 2) ? 1 : 0);
            chk($sformatf("step%0d_ball_hold", s), int'(bus.ball_hold), (v.est != 2) ? 1 : 0);
            if (v.est == 4)
                chk($sformatf("step%0d_winner", s), int'(bus.winner), int'(v.ewin));
            chk($sformatf("step%0d_serve_pulses", s), serve_cnt - sv0, v.eser);
            chk($sformatf("step%0d_frame_ticks", s), ft_cnt - ft0, v.vs ? (v.ncyc + 9) / 10 : 0);
            $display("step %0d: state=%0d score=%0d/%0d dir=%0d winner=%0d serves=%0d",
                     s, bus.state, bus.score_left, bus.score_right, bus.serve_dir,
                     bus.winner, serve_cnt - sv0);
        end
        chk("serve_only_in_play", serve_bad, 0);

        // Reset mid-PLAY at 1/1 with start already held high
        bus.start_button = 1'b1;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_state", int'(bus.state), 0);
        chk("midrst_sl", int'(bus.score_left), 0);
        chk("midrst_sr", int'(bus.score_right), 0);
        chk("midrst_serve", int'(bus.ball_serve), 0);
        chk("midrst_hold", int'(bus.ball_hold), 1);
        $display("mid-play reset: state=%0d score=%0d/%0d", bus.state, bus.score_left, bus.score_right);
        repeat (20) cyc();
        chk("held_start_no_restart", int'(bus.state), 0);
        bus.start_button = 1'b0;
        cyc();
        bus.start_button = 1'b1;
        cyc();
        bus.start_button = 1'b0;
        chk("repress_start_serve", int'(bus.state), 1);
        chk("repress_pe", int'(bus.paddle_enable), 1);
        $display("re-press: state=%0d", bus.state);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
- Match-level sequencer for the two-paddle game. Derives the per-frame game tick from vertical_sync and runs the match state machine: idle, serve countdown, play, point freeze and game over.
- Gates the paddle movers through paddle_enable and holds or launches the ball logic.
- Keeps both scores and declares the winner.
- Sits between the video timing, the player inputs and the paddle/ball blocks. It is the single owner of "when things may move".

Parameters:
- SCORE_WIDTH, 4, width of each score register.
- WIN_SCORE, 4'd7, score that ends the match. Must be ≥1 and < 2**SCORE_WIDTH.
- COUNT_WIDTH, 8, width of the frame countdown counter.
- SERVE_FRAMES, 8'd60, frame ticks spent in SERVE before launch. A value of 0 behaves as 1.
- POINT_FRAMES, 8'd30, frame ticks spent in POINT after a score. A value of 0 behaves as 1.

Ports:
- pixel_clock, input, 1: sole clock; all logic on posedge.
- reset, input, 1: synchronous, active-high.
- vertical_sync, input, 1: raw vsync level; a rising edge is one game frame.
- start_button, input, 1: level; internally rising-edge detected.
- ball_out_left, input, 1: level; ball has passed the left goal line (right player scores).
- ball_out_right, input, 1: level; ball has passed the right goal line (left player scores).
- frame_tick, output, 1: one-cycle pulse per vsync rising edge.
- paddle_enable, output, 1: paddles may move.
- ball_hold, output, 1: ball held at centre, not moving.
- ball_serve, output, 1: one-cycle launch pulse.
- serve_dir, output, 1: launch direction; 0 = toward left, 1 = toward right.
- score_left, output, SCORE_WIDTH: left player score.
- score_right, output, SCORE_WIDTH: right player score.
- winner, output, 1: 0 = left, 1 = right; valid only in GAME_OVER.
- state, output, 3: current state encoding.

Behaviour:
- Edge detectors:
  - last_vsync and last_start are registered every cycle.
  - On reset both are set to 1, so an input already high at reset release is not an edge.
  - tick = vertical_sync & ~last_vsync.
  - start_edge = start_button & ~last_start.
- frame_tick:
  - Registered copy of tick: high exactly one cycle, in the cycle after the edge that sampled the rising vsync.
  - Free-running in all states except during reset.
- State encoding: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAME_OVER=4. Codes 5–7 are illegal and go to IDLE on the next clock.
- Reset values (all registered outputs):
  - state=IDLE, score_left=0, score_right=0, serve_dir=0, winner=0.
  - ball_serve=0, frame_tick=0, paddle_enable=0, ball_hold=1, countdown=0.
- Reset mid-operation: abandons the match and forces the reset values on the next clock, whatever the state.
- Countdown:
  - Loaded with max(DELAY,1) on the clock that enters SERVE or POINT.
  - Decrements on each tick while in that state.
  - The state exits on the tick that finds countdown==1, i.e. exactly DELAY ticks after entry.
  - Ticks occurring in the entry cycle do not count.
- IDLE:
  - start_edge → clear both scores, serve_dir=0, enter SERVE.
- SERVE:
  - Countdown of SERVE_FRAMES ticks, then enter PLAY.
  - ball_serve pulses high for the single cycle after that transition edge, i.e. the first cycle in PLAY.
  - ball_out_* are ignored in this state.
- PLAY:
  - Goal inputs are sampled every clock, not only on ticks.
  - ball_out_left alone → score_right+1, serve_dir=0 (serve toward the conceding player), enter POINT.
  - ball_out_right alone → score_left+1, serve_dir=1, enter POINT.
  - Both inputs high in the same cycle → no score change, serve_dir unchanged, enter POINT (replayed point).
  - start_edge is ignored.
- POINT:
  - Countdown of POINT_FRAMES ticks.
  - On expiry: if either score == WIN_SCORE, enter GAME_OVER and set winner (1 if score_right==WIN_SCORE); otherwise enter SERVE.
  - Goal inputs are ignored, so a held ball_out level cannot double-score.
- GAME_OVER:
  - Scores are frozen.
  - start_edge → clear scores, serve_dir=0, enter SERVE (new match directly).
- Score arithmetic:
  - Unsigned, SCORE_WIDTH bits, incremented by 1.
  - Saturates at WIN_SCORE; never wraps.
- Combinational decode of the registered state:
  - paddle_enable = (state==SERVE)|(state==PLAY).
  - ball_hold = (state!=PLAY).
- Simultaneous start_edge and countdown expiry are impossible by construction, since start only acts in IDLE and GAME_OVER.

Test Plan (all with SERVE_FRAMES=3, POINT_FRAMES=2, WIN_SCORE=2, vsync rising every 10 cycles):
- Reset → state=0, scores 0/0, ball_hold=1, paddle_enable=0. Holding vertical_sync=1 through reset release → no frame_tick until vsync falls and rises again.
- start pulse in IDLE → SERVE with paddle_enable=1. Exactly 3 ticks later → PLAY and a single-cycle ball_serve with serve_dir=0.
- In PLAY, ball_out_right=1 held for 50 cycles → score_left=1 exactly once, serve_dir=1, POINT for 2 ticks, then SERVE.
- In PLAY, ball_out_left and ball_out_right both asserted in the same cycle → scores unchanged, POINT then SERVE.
- Left scores twice → after the POINT countdown, state=GAME_OVER, winner=0, scores 2/0 frozen. Further ball_out pulses → no change. A start pulse → scores 0/0, SERVE.
- Assert reset for 1 cycle while in PLAY with scores 1/1 → next cycle state=IDLE, scores 0/0, ball_serve=0; a start level already held high → no restart until it is released and re-pressed.
